// File: rtl/multi_bank_buffer_pkg.sv
// Shared sizing helpers for the multi-bank ring buffer.
package multi_bank_buffer_pkg;

  localparam int DEF_DATA_WIDTH      = 64;
  localparam int DEF_BANK_ADDR_WIDTH = 7;
  localparam int DEF_BANK_DEPTH      = 128;
  localparam int DEF_NUM_BANKS       = 4;

  function automatic int ptr_width(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int total_depth(input int num_banks, input int bank_depth);
    return num_banks * bank_depth;
  endfunction

  function automatic int phys_addr_width(input int bank_addr_width, input int num_banks);
    return bank_addr_width + ptr_width(num_banks);
  endfunction

endpackage

// File: rtl/bank_ring_ctrl.sv
// Bank ring bookkeeping: pointers, occupancy, flow-control flags and access gating.
// Define MULTI_BANK_BUFFER_PROT_CHECK_EN to make err a sticky protocol-violation flag.
module bank_ring_ctrl
  import multi_bank_buffer_pkg::*;
#(
  parameter  int NUM_BANKS = DEF_NUM_BANKS,
  localparam int PW        = ptr_width(NUM_BANKS),
  localparam int CW        = $clog2(NUM_BANKS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic          wr_commit,
  input  logic          ren,
  input  logic          rd_release,
  output logic [PW-1:0] wptr,
  output logic [PW-1:0] rptr,
  output logic          ram_wen,
  output logic          ram_ren,
  output logic          wr_ready,
  output logic          rd_valid,
  output logic [CW-1:0] num_full,
  output logic          rvalid,
  output logic          err
);

  logic [CW-1:0] count;
  logic          commit_ok;
  logic          release_ok;

  assign wr_ready   = (count != CW'(NUM_BANKS));
  assign rd_valid   = (count != '0);
  assign ram_wen    = wen & wr_ready;
  assign ram_ren    = ren & rd_valid;
  assign commit_ok  = wr_commit & wr_ready;
  assign release_ok = rd_release & rd_valid;
  assign num_full   = count;

  // Pointers are power-of-two wide, so +1 wraps the ring for free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      rvalid <= 1'b0;
    end else begin
      if (commit_ok)  wptr <= wptr + PW'(1);
      if (release_ok) rptr <= rptr + PW'(1);
      case ({commit_ok, release_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rvalid <= ram_ren;
    end
  end

`ifdef MULTI_BANK_BUFFER_PROT_CHECK_EN
  logic proto_err;

  assign proto_err = (wen & ~wr_ready) | (wr_commit & ~wr_ready) |
                     (ren & ~rd_valid) | (rd_release & ~rd_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err | proto_err;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/ram_sync_1r1w.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
module ram_sync_1r1w #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/multi_bank_buffer.sv
// Ring of NUM_BANKS equal banks in one RAM with ready/valid bank hand-off.
// Optional sticky protocol check: MULTI_BANK_BUFFER_PROT_CHECK_EN.
module multi_bank_buffer
  import multi_bank_buffer_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
  parameter int BANK_DEPTH      = DEF_BANK_DEPTH,
  parameter int NUM_BANKS       = DEF_NUM_BANKS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wen,
  input  logic [BANK_ADDR_WIDTH-1:0]   wadr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic                         wr_commit,
  output logic                         wr_ready,
  input  logic                         ren,
  input  logic [BANK_ADDR_WIDTH-1:0]   radr,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic                         rvalid,
  input  logic                         rd_release,
  output logic                         rd_valid,
  output logic [$clog2(NUM_BANKS):0]   num_full,
  output logic                         err
);

  localparam int PW    = ptr_width(NUM_BANKS);
  localparam int AW    = phys_addr_width(BANK_ADDR_WIDTH, NUM_BANKS);
  localparam int DEPTH = total_depth(NUM_BANKS, BANK_DEPTH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          ram_wen;
  logic          ram_ren;

  bank_ring_ctrl #(
    .NUM_BANKS (NUM_BANKS)
  ) u_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .wr_commit  (wr_commit),
    .ren        (ren),
    .rd_release (rd_release),
    .wptr       (wptr),
    .rptr       (rptr),
    .ram_wen    (ram_wen),
    .ram_ren    (ram_ren),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .num_full   (num_full),
    .rvalid     (rvalid),
    .err        (err)
  );

  // Bank select in the upper address bits; same-cycle commit/release still use the old bank.
  ram_sync_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .wen   (ram_wen),
    .waddr ({wptr, wadr}),
    .wdata (wdata),
    .ren   (ram_ren),
    .raddr ({rptr, radr}),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_multi_bank_buffer.sv
// Scoreboard bench for multi_bank_buffer: reads push expected data, a monitor pops on rvalid.
module tb_multi_bank_buffer;

  localparam int DW  = 64;
  localparam int BAW = 7;
  localparam int NB  = 4;
  localparam int CW  = 3;
`ifdef MULTI_BANK_BUFFER_PROT_CHECK_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wen = 1'b0;
  logic [BAW-1:0] wadr = '0;
  logic [DW-1:0]  wdata = '0;
  logic           wr_commit = 1'b0;
  logic           wr_ready;
  logic           ren = 1'b0;
  logic [BAW-1:0] radr = '0;
  logic [DW-1:0]  rdata;
  logic           rvalid;
  logic           rd_release = 1'b0;
  logic           rd_valid;
  logic [CW-1:0]  num_full;
  logic           err;

  multi_bank_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wen        (wen),
    .wadr       (wadr),
    .wdata      (wdata),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .ren        (ren),
    .radr       (radr),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rd_release (rd_release),
    .rd_valid   (rd_valid),
    .num_full   (num_full),
    .err        (err)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           passed = 0;
  logic [DW-1:0] exp_q[$];
  int           mcount = 0;
  bit           err_exp = 1'b0;
  int           tag_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every rvalid must match the oldest outstanding accepted read.
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) check("rvalid_unexpected", {63'd0, rvalid}, 64'd0);
      else check("rdata", rdata, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of stimulus; the model decides acceptance from its own occupancy count.
  task automatic cyc(input bit w, input int wa, input logic [63:0] wd, input bit c,
                     input bit r, input int ra, input logic [63:0] rexp, input bit rl);
    bit wok = (mcount != NB);
    bit rok = (mcount != 0);
    wen = w; wadr = BAW'(wa); wdata = wd; wr_commit = c;
    ren = r; radr = BAW'(ra); rd_release = rl;
    if (r && rok) exp_q.push_back(rexp);
    if (PROT && ((w && !wok) || (c && !wok) || (r && !rok) || (rl && !rok))) err_exp = 1'b1;
    mcount += int'(c && wok) - int'(rl && rok);
    tick();
    wen = 1'b0; wr_commit = 1'b0; ren = 1'b0; rd_release = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mcount = 0;
    err_exp = 1'b0;
    tag_q.delete();
  endtask

  function automatic logic [63:0] dat(input int tag, input int adr);
    return 64'((tag << 8) | adr);
  endfunction

  // Full mode writes every word; short mode writes words 0, 5, 127. Last write carries commit/release.
  task automatic write_bank(input int tag, input bit full, input bit c, input bit rl);
    int adrs[3] = '{0, 5, 127};
    if (full) begin
      for (int a = 0; a < 128; a++) cyc(1, a, dat(tag, a), c && a == 127, 0, 0, 0, rl && a == 127);
    end else begin
      for (int i = 0; i < 3; i++) cyc(1, adrs[i], dat(tag, adrs[i]), c && i == 2, 0, 0, 0, rl && i == 2);
    end
    if (c && mcount <= NB) tag_q.push_back(tag);
  endtask

  task automatic read_bank(input int tag, input bit rl);
    int adrs[3] = '{5, 0, 127};
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, adrs[i], dat(tag, adrs[i]), rl && i == 2);
  endtask

  task automatic check_flags(input string name);
    check({name, "_wr_ready"}, {63'd0, wr_ready}, {63'd0, mcount != NB});
    check({name, "_rd_valid"}, {63'd0, rd_valid}, {63'd0, mcount != 0});
    check({name, "_num_full"}, {61'd0, num_full}, 64'(mcount));
    check({name, "_err"}, {63'd0, err}, {63'd0, err_exp});
  endtask

  initial begin
    do_reset();
    check("reset_wr_ready", {63'd0, wr_ready}, 64'd1);
    check("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
    check("reset_num_full", {61'd0, num_full}, 64'd0);
    check("reset_rvalid", {63'd0, rvalid}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);

    // Bank 0 full fill; commit shares the cycle with the last write.
    write_bank(1, 1, 1, 0);
    check("fill_num_full", {61'd0, num_full}, 64'd1);
    cyc(0, 0, 0, 0, 1, 5, 64'h105, 0);
    cyc(0, 0, 0, 0, 1, 127, 64'h17f, 1);   // read of old bank alongside release
    idle();
    check("release_num_full", {61'd0, num_full}, 64'd0);
    check("release_rd_valid", {63'd0, rd_valid}, 64'd0);

    // Reset mid-operation discards occupancy.
    write_bank(2, 0, 1, 0);
    check("pre_reset_num_full", {61'd0, num_full}, 64'd1);
    do_reset();
    check_flags("mid_reset");

    // Fill all four banks, then try to overrun.
    for (int b = 0; b < NB; b++) write_bank(8'h20 + b, 0, 1, 0);
    check("full_num_full", {61'd0, num_full}, 64'd4);
    check("full_wr_ready", {63'd0, wr_ready}, 64'd0);
    cyc(1, 5, 64'hdead, 1, 0, 0, 0, 0);
    check_flags("overrun");
    cyc(0, 0, 0, 0, 1, 5, 64'h2005, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 64'h2100, 1);
    check("two_left_num_full", {61'd0, num_full}, 64'd2);

    // Commit and release together at num_full=2.
    write_bank(8'h30, 0, 1, 1);
    check("simul_num_full", {61'd0, num_full}, 64'd2);
    cyc(0, 0, 0, 0, 1, 5, 64'h2305, 1);
    cyc(0, 0, 0, 0, 1, 5, 64'h3005, 1);    // rptr wrapped 3 -> 0
    check_flags("drained");

    // Commit plus release at empty: only the commit lands.
    write_bank(8'h40, 0, 1, 1);
    check("empty_simul_num_full", {61'd0, num_full}, 64'd1);
    tag_q.delete();
    tag_q.push_back(8'h40);

    // Six rounds with one bank in flight; pointers wrap more than once.
    for (int r = 0; r < 6; r++) begin
      write_bank(8'h50 + r, 0, 1, 0);
      read_bank(tag_q.pop_front(), 1);
    end
    read_bank(tag_q.pop_front(), 1);
    idle();
    check_flags("rounds");

    // Protocol errors at empty.
    do_reset();
    check("err_clear", {63'd0, err}, 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    check("err_release_empty", {63'd0, err}, {63'd0, PROT});
    cyc(0, 0, 0, 0, 1, 3, 0, 0);
    idle();
    check("err_sticky", {63'd0, err}, {63'd0, PROT});
    check("empty_num_full", {61'd0, num_full}, 64'd0);
    do_reset();
    check("err_after_reset", {63'd0, err}, 64'd0);

    idle();
    idle();
    check("read_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
